// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU; single-cycle ops plus iterative one-bit-per-cycle shifts
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [3:0]       OP,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Error
);

    localparam logic [3:0] OP_LSH = 4'b0000;
    localparam logic [3:0] OP_RSH = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_GEQ = 4'b1000;
    localparam logic [3:0] OP_EQ  = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b1011;
    localparam logic [3:0] OP_NEQ = 4'b1101;

    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] ONE_S = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   out_q, out_n;
    logic               zero_q, zero_n;
    logic               carry_q, carry_n;
    logic               error_q, error_n;
    logic [SHAMT_W-1:0] count_q, count_n;
    logic               left_q, left_n;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = InputB[SHAMT_W-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
            left_q  <= 1'b0;
        end else begin
            state   <= state_n;
            out_q   <= out_n;
            zero_q  <= zero_n;
            carry_q <= carry_n;
            error_q <= error_n;
            count_q <= count_n;
            left_q  <= left_n;
        end
    end

    always_comb begin
        state_n = state;
        out_n   = out_q;
        zero_n  = zero_q;
        carry_n = carry_q;
        error_n = error_q;
        count_n = count_q;
        left_n  = left_q;

        case (state)
            IDLE: begin
                if (InValid) begin
                    state_n = DONE;
                    carry_n = 1'b0;
                    error_n = 1'b0;
                    case (OP)
                        OP_LSH, OP_RSH: begin
                            left_n = (OP == OP_LSH);
                            if (shamt == '0) begin
                                out_n = InputA;
                            end else begin
                                // First bit moves on the accept edge; the rest iterate in SHIFT.
                                if (OP == OP_LSH)
                                    {carry_n, out_n} = {InputA, 1'b0};
                                else
                                    {out_n, carry_n} = {1'b0, InputA};
                                if (shamt > ONE_S) begin
                                    count_n = shamt - ONE_S;
                                    state_n = SHIFT;
                                end
                            end
                        end
                        OP_AND: out_n = InputA & InputB;
                        OP_OR:  out_n = InputA | InputB;
                        OP_GEQ: out_n = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
                        OP_EQ:  out_n = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
                        OP_NEQ: out_n = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
                        OP_NEG: begin
                            out_n   = ~InputA + ONE_W;
                            carry_n = (InputA == '0);
                        end
                        OP_ADD: {carry_n, out_n} = {1'b0, InputA} + {1'b0, InputB};
                        default: begin
                            out_n   = '0;
                            error_n = 1'b1;
                        end
                    endcase
                    zero_n = (out_n == '0);
                end
            end
            SHIFT: begin
                if (left_q)
                    {carry_n, out_n} = {out_q, 1'b0};
                else
                    {out_n, carry_n} = {1'b0, out_q};
                zero_n  = (out_n == '0);
                count_n = count_q - ONE_S;
                if (count_q == ONE_S)
                    state_n = DONE;
            end
            DONE: begin
                if (OutReady)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign Out      = out_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;

    logic       Clk = 1'b0;
    logic       Reset, InValid, OutReady;
    logic       InReady, OutValid, Zero, Carry, Error;
    logic [7:0] InputA, InputB, Out;
    logic [3:0] OP;

    logic        Reset_w, InValid_w, OutReady_w;
    logic        InReady_w, OutValid_w, Zero_w, Carry_w, Error_w;
    logic [15:0] InputA_w, InputB_w, Out_w;
    logic [3:0]  OP_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    alu_seq #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
        .OutReady(OutReady), .Out(Out), .Zero(Zero), .Carry(Carry), .Error(Error)
    );

    alu_seq #(.WIDTH(16)) dut_w (
        .Clk(Clk), .Reset(Reset_w), .InValid(InValid_w), .InReady(InReady_w),
        .InputA(InputA_w), .InputB(InputB_w), .OP(OP_w), .OutValid(OutValid_w),
        .OutReady(OutReady_w), .Out(Out_w), .Zero(Zero_w), .Carry(Carry_w), .Error(Error_w)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       zero;
        logic       carry;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one op, then count edges until OutValid; inputs are scrambled after accept.
    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        InValid = 1'b1; OP = op; InputA = a; InputB = b; OutReady = 1'b0;
        @(posedge Clk); #1;
        InValid = 1'b0; OP = 4'hC; InputA = 8'hAA; InputB = 8'hFF;
        lat = 1;
        while (!OutValid && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic release8(input string name);
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        chk({name, " in_ready after pop"}, 32'(InReady), 32'd1);
        chk({name, " out_valid after pop"}, 32'(OutValid), 32'd0);
    endtask

    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output int lat);
        InValid_w = 1'b1; OP_w = op; InputA_w = a; InputB_w = b; OutReady_w = 1'b0;
        @(posedge Clk); #1;
        InValid_w = 1'b0; InputA_w = 16'h5555;
        lat = 1;
        while (!OutValid_w && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        string nm;

        vecs[0]  = '{4'b1011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[1]  = '{4'b1010, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'b1010, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'b0000, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 3};
        vecs[4]  = '{4'b0001, 8'h81, 8'h01, 8'h40, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{4'b0000, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'b1000, 8'h03, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'b1001, 8'h02, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'b1101, 8'h01, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'b0011, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{4'b0100, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1};
        vecs[11] = '{4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{4'b0001, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 7};
        vecs[13] = '{4'b0000, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 3};
        vecs[14] = '{4'b1011, 8'h05, 8'h06, 8'h0B, 1'b0, 1'b0, 1'b0, 1};
        vecs[15] = '{4'b0000, 8'hFF, 8'h02, 8'hFC, 1'b0, 1'b1, 1'b0, 2};
        vecs[16] = '{4'b1000, 8'h04, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{4'b1111, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1};

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; OP = '0; InputA = '0; InputB = '0;
        Reset_w = 1'b1; InValid_w = 1'b0; OutReady_w = 1'b0; OP_w = '0;
        InputA_w = '0; InputB_w = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0; Reset_w = 1'b0;

        chk("reset out", 32'(Out), 32'h0);
        chk("reset zero", 32'(Zero), 32'd0);
        chk("reset carry", 32'(Carry), 32'd0);
        chk("reset error", 32'(Error), 32'd0);
        chk("reset out_valid", 32'(OutValid), 32'd0);
        chk("reset in_ready", 32'(InReady), 32'd1);

        for (int i = 0; i < 18; i++) begin
            issue8(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            nm = $sformatf("vec%0d", i);
            chk({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            chk({nm, " out"}, 32'(Out), 32'(vecs[i].out));
            chk({nm, " zero"}, 32'(Zero), 32'(vecs[i].zero));
            chk({nm, " carry"}, 32'(Carry), 32'(vecs[i].carry));
            chk({nm, " error"}, 32'(Error), 32'(vecs[i].err));
            release8(nm);
        end

        // Backpressure: result held while stray requests arrive during DONE.
        issue8(4'b1011, 8'h05, 8'h06, lat);
        chk("bp latency", 32'(lat), 32'd1);
        for (int c = 0; c < 4; c++) begin
            InValid = 1'b1; OP = 4'b0010; InputA = 8'h00; InputB = 8'h00;
            @(posedge Clk); #1;
            chk("bp out held", 32'(Out), 32'h0B);
            chk("bp out_valid held", 32'(OutValid), 32'd1);
            chk("bp in_ready low", 32'(InReady), 32'd0);
            chk("bp zero held", 32'(Zero), 32'd0);
        end
        InValid = 1'b0;
        release8("bp");
        @(posedge Clk); #1;
        chk("bp no queued op", 32'(OutValid), 32'd0);
        chk("bp idle out", 32'(Out), 32'h0B);

        // Reset on the third SHIFT edge of RSH 80,07.
        InValid = 1'b1; OP = 4'b0001; InputA = 8'h80; InputB = 8'h07;
        @(posedge Clk); #1;
        InValid = 1'b0;
        repeat (2) begin
            @(posedge Clk); #1;
        end
        chk("mid-shift out_valid", 32'(OutValid), 32'd0);
        chk("mid-shift out", 32'(Out), 32'h10);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst shift out_valid", 32'(OutValid), 32'd0);
        chk("rst shift in_ready", 32'(InReady), 32'd1);
        chk("rst shift out", 32'(Out), 32'h00);
        issue8(4'b1011, 8'h01, 8'h01, lat);
        chk("post-rst add latency", 32'(lat), 32'd1);
        chk("post-rst add out", 32'(Out), 32'h02);
        release8("post-rst");

        // Reset while holding a result in DONE.
        issue8(4'b0011, 8'h0F, 8'hF0, lat);
        chk("done or out", 32'(Out), 32'hFF);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst done out_valid", 32'(OutValid), 32'd0);
        chk("rst done out", 32'(Out), 32'h00);

        // WIDTH=16 shifts.
        issue16(4'b0000, 16'h0001, 16'h000F, lat);
        chk("w16 lsh latency", 32'(lat), 32'd15);
        chk("w16 lsh out", 32'(Out_w), 32'h8000);
        chk("w16 lsh carry", 32'(Carry_w), 32'd0);
        OutReady_w = 1'b1;
        @(posedge Clk); #1;
        OutReady_w = 1'b0;
        chk("w16 pop in_ready", 32'(InReady_w), 32'd1);
        issue16(4'b0001, 16'h8000, 16'hFF0F, lat);
        chk("w16 rsh latency", 32'(lat), 32'd15);
        chk("w16 rsh out", 32'(Out_w), 32'h0001);
        chk("w16 rsh error", 32'(Error_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
